uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Serial receiver feeding the UART protocol decoder: deserialises 8N1 frames from i_rx.
//  Presents each good byte on o_dat with a one-cycle o_received_pulse.
//  These drive the decoder's i_uart_dat / i_uart_received_pulse directly.
//  No FIFO: the decoder consumes each byte in the pulse cycle.
// PARAMETERS
//  CLKS_PER_BIT  104  i_clk cycles per bit (12 MHz / 115200); legal range >= 4
// PORTS
//  i_clk             in   1  system clock
//  i_reset           in   1  synchronous, active-high reset
//  i_rx              in   1  asynchronous serial line, idle high
//  o_dat             out  8  last correctly framed byte; held until the next good byte
//  o_received_pulse  out  1  1-cycle strobe: o_dat valid and new in this cycle
//  o_frame_err       out  1  1-cycle strobe: stop bit sampled low, byte discarded
//  o_busy            out  1  high whenever FSM != IDLE
// BEHAVIOUR
//  - Sync: 2-FF synchroniser i_rx -> rx_s; both FFs reset to 0. FSM uses rx_s only.
//  - H = CLKS_PER_BIT/2 (integer divide). Counter width $clog2(CLKS_PER_BIT).
//  - Counter rule: each edge with cnt!=0 decrements; the edge with cnt==0 is the sample edge.
//  - States and transitions:
//    - WAIT_IDLE: exit to IDLE on the first edge with rx_s==1.
//    - IDLE: rx_s==0 -> START, cnt=H-1.
//    - START, sample edge: rx_s==0 -> DATA, cnt=CLKS_PER_BIT-1, bit_idx=0.
//      rx_s==1 is a glitch -> IDLE, no strobe.
//    - DATA, sample edge: shift rx_s into the MSB of the shift register (LSB first, shift right).
//      bit_idx++ and cnt reloaded to CLKS_PER_BIT-1. After the 8th bit -> STOP.
//    - STOP, sample edge: rx_s==1 -> o_dat<=shreg, o_received_pulse<=1, go IDLE.
//      rx_s==0 -> o_frame_err<=1, o_dat unchanged, go WAIT_IDLE (break/low line is ignored).
//  - Return to IDLE happens at the stop mid-sample, so back-to-back frames with zero idle are accepted.
//  - Strobes are registered and never asserted together. Each is high for exactly 1 cycle.
//  - Latency: let E0 be the edge at which sync FF1 first captures a low start bit.
//    o_received_pulse is high in the cycle following edge E0+2+H+9*CLKS_PER_BIT.
//    With CLKS_PER_BIT=104 that edge is E0+990.
//  - Reset values:
//    - FSM = WAIT_IDLE; o_dat = 8'h00; o_received_pulse = 0; o_frame_err = 0; o_busy = 1.
//    - o_busy falls 3 cycles after reset release when the line idles high.
//    - Reset mid-frame aborts with no strobe. A low line at reset is never mistaken for a start bit.
//  - Timing tolerance: sampling at bit centre tolerates ±4% cumulative baud error over 10 bits.
// TESTING
//  - CLKS_PER_BIT=8, send 0x4C ('L'), 1 stop:
//    -> single o_received_pulse, in the cycle after edge E0+78; o_dat=0x4C; o_frame_err never high.
//  - Back-to-back 0x00, 0xFF, 0x55 with no idle between stop and next start:
//    -> three pulses, o_dat 0x00, 0xFF, 0x55 in order, spaced 10*CLKS_PER_BIT cycles.
//  - i_rx low for 2 cycles (< H) then high:
//    -> no strobes; o_busy high for <= H+3 cycles, then 0.
//  - Send 0xA5 with stop bit = 0, then hold the line low for 30 bit times, then high, then send 0x2C:
//    -> one o_frame_err and no pulse; o_dat keeps its previous value.
//    -> no events while the line is low; then a pulse with o_dat=0x2C.
//  - Assert i_reset for 1 cycle during data bit 4 of 0x52:
//    -> no strobe, o_dat=0x00; the following frame 0x2E is received correctly.
//  - CLKS_PER_BIT=104, source bit period 101 and then 107 cycles, byte 0x5A:
//    -> both received as 0x5A, no o_frame_err.

Source files
------------

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line in, decoded byte and strobes out.
// master is the receiver; slave is whoever drives the line and consumes bytes.
interface uart_rx_if;
   logic       rx;
   logic [7:0] dat;
   logic       received_pulse;
   logic       frame_err;
   logic       busy;

   modport master (
      input  rx,
      output dat,
      output received_pulse,
      output frame_err,
      output busy
   );

   modport slave (
      output rx,
      input  dat,
      input  received_pulse,
      input  frame_err,
      input  busy
   );
endinterface

// File: rtl/uart_rx.sv
// 8N1 serial receiver: 2-FF synchroniser, mid-bit sampling FSM, registered
// byte/strobe outputs for the protocol decoder.
module uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 104
) (
   input  logic      i_clk,
   input  logic      i_reset,
   uart_rx_if.master bus
);
   localparam int unsigned H    = CLKS_PER_BIT / 2;
   localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
   localparam logic [CntW-1:0] CntHalf = CntW'(H - 1);
   localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0] CntOne  = CntW'(1);

   typedef enum logic [2:0] {StWaitIdle, StIdle, StStart, StData, StStop} state_e;

   state_e          state_q, state_d;
   logic            sync1_q, rx_s_q;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shreg_q, shreg_d;
   logic [7:0]      dat_q, dat_d;
   logic            pulse_q, pulse_d;
   logic            ferr_q, ferr_d;
   logic            sample;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         sync1_q   <= 1'b0;
         rx_s_q    <= 1'b0;
         state_q   <= StWaitIdle;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shreg_q   <= '0;
         dat_q     <= '0;
         pulse_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         sync1_q   <= bus.rx;
         rx_s_q    <= sync1_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shreg_q   <= shreg_d;
         dat_q     <= dat_d;
         pulse_q   <= pulse_d;
         ferr_q    <= ferr_d;
      end
   end

   assign sample = (cnt_q == '0);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shreg_d   = shreg_q;
      dat_d     = dat_q;
      pulse_d   = 1'b0;
      ferr_d    = 1'b0;

      case (state_q)
         // A line held low (reset or break) must go high before any start bit counts.
         StWaitIdle: begin
            if (rx_s_q) state_d = StIdle;
         end
         StIdle: begin
            if (!rx_s_q) begin
               state_d = StStart;
               cnt_d   = CntHalf;
            end
         end
         StStart: begin
            if (!sample) begin
               cnt_d = cnt_q - CntOne;
            end else if (!rx_s_q) begin
               state_d   = StData;
               cnt_d     = CntFull;
               bit_idx_d = '0;
            end else begin
               state_d = StIdle;
            end
         end
         StData: begin
            if (!sample) begin
               cnt_d = cnt_q - CntOne;
            end else begin
               shreg_d   = {rx_s_q, shreg_q[7:1]};
               cnt_d     = CntFull;
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) state_d = StStop;
            end
         end
         StStop: begin
            if (!sample) begin
               cnt_d = cnt_q - CntOne;
            end else if (rx_s_q) begin
               dat_d   = shreg_q;
               pulse_d = 1'b1;
               state_d = StIdle;
            end else begin
               ferr_d  = 1'b1;
               state_d = StWaitIdle;
            end
         end
         default: state_d = StWaitIdle;
      endcase
   end

   assign bus.dat            = dat_q;
   assign bus.received_pulse = pulse_q;
   assign bus.frame_err      = ferr_q;
   assign bus.busy           = (state_q != StIdle);
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one instance at 8 clocks/bit for functional cases,
// one at 104 clocks/bit for baud-tolerance frames.
module tb_uart_rx;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rx8 = 1'b0;
   logic rx104 = 1'b0;
   int   cyc = 0;

   int checks = 0;
   int passed = 0;

   uart_rx_if if8 ();
   uart_rx_if if104 ();

   assign if8.rx   = rx8;
   assign if104.rx = rx104;

   uart_rx #(.CLKS_PER_BIT(8)) dut8 (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (if8.master)
   );

   uart_rx #(.CLKS_PER_BIT(104)) dut104 (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (if104.master)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Event monitor; tasks only read these, taking deltas against snapshots.
   int         pulse8 = 0, ferr8 = 0, both8 = 0, wide8 = 0, busy_cyc8 = 0;
   int         pulse104 = 0, ferr104 = 0, both104 = 0, wide104 = 0;
   int         pcyc8[$];
   logic [7:0] pdat8[$];
   logic [7:0] pdat104[$];
   logic       prev_p8 = 1'b0, prev_f8 = 1'b0, prev_p104 = 1'b0, prev_f104 = 1'b0;

   always @(negedge clk) begin
      if (if8.received_pulse) begin
         pulse8++;
         pcyc8.push_back(cyc);
         pdat8.push_back(if8.dat);
      end
      if (if8.frame_err) ferr8++;
      if (if8.received_pulse && if8.frame_err) both8++;
      if ((if8.received_pulse && prev_p8) || (if8.frame_err && prev_f8)) wide8++;
      if (if8.busy) busy_cyc8++;
      prev_p8 = if8.received_pulse;
      prev_f8 = if8.frame_err;

      if (if104.received_pulse) begin
         pulse104++;
         pdat104.push_back(if104.dat);
      end
      if (if104.frame_err) ferr104++;
      if (if104.received_pulse && if104.frame_err) both104++;
      if ((if104.received_pulse && prev_p104) || (if104.frame_err && prev_f104)) wide104++;
      prev_p104 = if104.received_pulse;
      prev_f104 = if104.frame_err;
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_line(input bit sel, input logic v);
      if (sel) rx104 = v;
      else rx8 = v;
   endtask

   task automatic send_frame(input bit sel, input logic [7:0] b, input logic stop_bit,
                             input int per);
      logic [9:0] bits;
      bits = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         set_line(sel, bits[i]);
         wait_cycles(per);
      end
   endtask

   task automatic test_reset();
      int p0;
      rst = 1'b1;
      rx8 = 1'b0;
      rx104 = 1'b0;
      wait_cycles(3);
      checks++; if (if8.busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", if8.busy);
      else passed++;
      checks++; if (if8.dat !== 8'h00) $display("FAIL reset_dat: got %h want 00", if8.dat);
      else passed++;
      checks++;
      if (if8.received_pulse !== 1'b0 || if8.frame_err !== 1'b0)
         $display("FAIL reset_strobes: got %b%b want 00", if8.received_pulse, if8.frame_err);
      else passed++;
      // Release with the line low: must not be taken as a start bit.
      p0 = pulse8 + ferr8;
      rst = 1'b0;
      wait_cycles(20);
      checks++; if (if8.busy !== 1'b1) $display("FAIL low_line_busy: got %b want 1", if8.busy);
      else passed++;
      checks++;
      if (pulse8 + ferr8 !== p0) $display("FAIL low_line_events: got %0d want 0", pulse8 + ferr8 - p0);
      else passed++;
      rx8 = 1'b1;
      rx104 = 1'b1;
      wait_cycles(10);
      // Release with the line high: busy drops on the third edge.
      rst = 1'b1;
      wait_cycles(2);
      rst = 1'b0;
      wait_cycles(2);
      checks++; if (if8.busy !== 1'b1) $display("FAIL busy_after2: got %b want 1", if8.busy);
      else passed++;
      wait_cycles(1);
      checks++; if (if8.busy !== 1'b0) $display("FAIL busy_after3: got %b want 0", if8.busy);
      else passed++;
      checks++; if (if104.busy !== 1'b0) $display("FAIL busy104_after3: got %b want 0", if104.busy);
      else passed++;
   endtask

   task automatic test_single();
      int p0, f0, q0, t0, got;
      p0 = pulse8; f0 = ferr8; q0 = pcyc8.size();
      t0 = cyc;
      send_frame(1'b0, 8'h4C, 1'b1, 8);
      wait_cycles(8);
      checks++; if (pulse8 - p0 !== 1) $display("FAIL single_count: got %0d want 1", pulse8 - p0);
      else passed++;
      got = (pcyc8.size() > q0) ? pcyc8[q0] : -1;
      checks++; if (got !== t0 + 79) $display("FAIL single_latency: got %0d want %0d", got, t0 + 79);
      else passed++;
      checks++; if (if8.dat !== 8'h4C) $display("FAIL single_dat: got %h want 4c", if8.dat);
      else passed++;
      checks++; if (ferr8 !== f0) $display("FAIL single_ferr: got %0d want 0", ferr8 - f0);
      else passed++;
   endtask

   task automatic test_back_to_back();
      int         p0, q0, t0, gc;
      logic [7:0] exp_dat [3];
      logic [7:0] gd;
      exp_dat = '{8'h00, 8'hFF, 8'h55};
      p0 = pulse8; q0 = pcyc8.size();
      t0 = cyc;
      for (int i = 0; i < 3; i++) send_frame(1'b0, exp_dat[i], 1'b1, 8);
      wait_cycles(8);
      checks++; if (pulse8 - p0 !== 3) $display("FAIL b2b_count: got %0d want 3", pulse8 - p0);
      else passed++;
      for (int i = 0; i < 3; i++) begin
         gd = (pdat8.size() > q0 + i) ? pdat8[q0 + i] : 8'hxx;
         gc = (pcyc8.size() > q0 + i) ? pcyc8[q0 + i] : -1;
         checks++;
         if (gd !== exp_dat[i]) $display("FAIL b2b_dat%0d: got %h want %h", i, gd, exp_dat[i]);
         else passed++;
         checks++;
         if (gc !== t0 + 79 + 80 * i)
            $display("FAIL b2b_cyc%0d: got %0d want %0d", i, gc, t0 + 79 + 80 * i);
         else passed++;
      end
      checks++; if (if8.dat !== 8'h55) $display("FAIL b2b_hold: got %h want 55", if8.dat);
      else passed++;
   endtask

   task automatic test_glitch();
      int p0, f0, b0, nb;
      p0 = pulse8; f0 = ferr8; b0 = busy_cyc8;
      rx8 = 1'b0;
      wait_cycles(2);
      rx8 = 1'b1;
      wait_cycles(20);
      nb = busy_cyc8 - b0;
      checks++;
      if (pulse8 !== p0 || ferr8 !== f0)
         $display("FAIL glitch_events: got %0d want 0", pulse8 - p0 + ferr8 - f0);
      else passed++;
      checks++; if (nb < 1 || nb > 7) $display("FAIL glitch_busy_len: got %0d want 1..7", nb);
      else passed++;
      checks++; if (if8.busy !== 1'b0) $display("FAIL glitch_busy_end: got %b want 0", if8.busy);
      else passed++;
   endtask

   task automatic test_frame_err();
      int p0, f0;
      p0 = pulse8; f0 = ferr8;
      send_frame(1'b0, 8'hA5, 1'b0, 8);
      wait_cycles(30 * 8);
      checks++; if (ferr8 - f0 !== 1) $display("FAIL ferr_count: got %0d want 1", ferr8 - f0);
      else passed++;
      checks++; if (pulse8 !== p0) $display("FAIL ferr_pulse: got %0d want 0", pulse8 - p0);
      else passed++;
      checks++; if (if8.dat !== 8'h55) $display("FAIL ferr_dat_kept: got %h want 55", if8.dat);
      else passed++;
      checks++; if (if8.busy !== 1'b1) $display("FAIL ferr_busy_low: got %b want 1", if8.busy);
      else passed++;
      rx8 = 1'b1;
      wait_cycles(8);
      checks++; if (if8.busy !== 1'b0) $display("FAIL ferr_recover: got %b want 0", if8.busy);
      else passed++;
      send_frame(1'b0, 8'h2C, 1'b1, 8);
      wait_cycles(8);
      checks++;
      if (pulse8 - p0 !== 1 || if8.dat !== 8'h2C)
         $display("FAIL ferr_next: got %0d/%h want 1/2c", pulse8 - p0, if8.dat);
      else passed++;
      checks++; if (ferr8 - f0 !== 1) $display("FAIL ferr_after: got %0d want 1", ferr8 - f0);
      else passed++;
   endtask

   task automatic test_reset_midframe();
      int         p0, f0;
      logic [9:0] bits;
      bits = {1'b1, 8'h52, 1'b0};
      p0 = pulse8; f0 = ferr8;
      for (int i = 0; i < 5; i++) begin
         rx8 = bits[i];
         wait_cycles(8);
      end
      rx8 = bits[5];
      wait_cycles(4);
      rst = 1'b1;
      wait_cycles(1);
      rst = 1'b0;
      // The transmitter is taken down by the same reset, so the line returns to idle.
      rx8 = 1'b1;
      wait_cycles(24);
      checks++;
      if (pulse8 !== p0 || ferr8 !== f0)
         $display("FAIL midrst_events: got %0d want 0", pulse8 - p0 + ferr8 - f0);
      else passed++;
      checks++; if (if8.dat !== 8'h00) $display("FAIL midrst_dat: got %h want 00", if8.dat);
      else passed++;
      send_frame(1'b0, 8'h2E, 1'b1, 8);
      wait_cycles(8);
      checks++;
      if (pulse8 - p0 !== 1 || if8.dat !== 8'h2E)
         $display("FAIL midrst_next: got %0d/%h want 1/2e", pulse8 - p0, if8.dat);
      else passed++;
   endtask

   task automatic test_baud();
      int         p0, f0, q0;
      logic [7:0] gd;
      p0 = pulse104; f0 = ferr104; q0 = pdat104.size();
      send_frame(1'b1, 8'h5A, 1'b1, 101);
      wait_cycles(208);
      send_frame(1'b1, 8'h5A, 1'b1, 107);
      wait_cycles(208);
      checks++; if (pulse104 - p0 !== 2) $display("FAIL baud_count: got %0d want 2", pulse104 - p0);
      else passed++;
      for (int i = 0; i < 2; i++) begin
         gd = (pdat104.size() > q0 + i) ? pdat104[q0 + i] : 8'hxx;
         checks++; if (gd !== 8'h5A) $display("FAIL baud_dat%0d: got %h want 5a", i, gd);
         else passed++;
      end
      checks++; if (ferr104 !== f0) $display("FAIL baud_ferr: got %0d want 0", ferr104 - f0);
      else passed++;
   endtask

   task automatic test_strobe_rules();
      checks++; if (both8 + both104 !== 0) $display("FAIL strobes_together: got %0d want 0", both8 + both104);
      else passed++;
      checks++; if (wide8 + wide104 !== 0) $display("FAIL strobe_width: got %0d want 0", wide8 + wide104);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_glitch();
      test_frame_err();
      test_reset_midframe();
      test_baud();
      test_strobe_rules();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
